// File: rtl/tsv_fault_scan_if.sv
// Link-test bundle between the TSV fault scanner and its surroundings.
// The scanner itself uses the slave modport; the link/controller side uses master.
interface tsv_fault_scan_if #(
    parameter int N_TSV = 9
);
    localparam int CNT_W = $clog2(N_TSV + 1);

    logic             start;
    logic             tsv_test_en;
    logic [N_TSV-1:0] tsv_drive;
    logic [N_TSV-1:0] tsv_sense;
    logic [N_TSV-1:0] f_flag;
    logic [CNT_W-1:0] fault_cnt;
    logic             repair_ok;
    logic             busy;
    logic             done;

    modport slave (
        input  start,
        input  tsv_sense,
        output tsv_test_en,
        output tsv_drive,
        output f_flag,
        output fault_cnt,
        output repair_ok,
        output busy,
        output done
    );

    modport master (
        output start,
        output tsv_sense,
        input  tsv_test_en,
        input  tsv_drive,
        input  f_flag,
        input  fault_cnt,
        input  repair_ok,
        input  busy,
        input  done
    );
endinterface

// File: rtl/tsv_fault_scan.sv
// Built-in loopback test of the TSV link. Each TSV gets a walking-one phase
// and a walking-zero phase; failures accumulate in a shadow vector that is
// copied to f_flag in one go at the end so downstream adders never see a
// half-finished result.
module tsv_fault_scan #(
    parameter int N_TSV      = 9,
    parameter int SETTLE     = 2,
    parameter int MAX_FAULTS = 1
) (
    input logic            clock,
    input logic            reset,
    tsv_fault_scan_if.slave scan
);
    localparam int IDX_W     = (N_TSV > 1) ? $clog2(N_TSV) : 1;
    localparam int CNT_W     = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam int POP_W     = $clog2(N_TSV + 1);
    localparam int MAX_CLAMP = (MAX_FAULTS > N_TSV) ? N_TSV : MAX_FAULTS;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TSV - 1);
    localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);
    localparam logic [POP_W-1:0] MAX_C    = POP_W'(MAX_CLAMP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ONE,
        S_ZERO,
        S_PUBLISH
    } state_t;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [N_TSV-1:0] shadow_reg, shadow_next;
    logic [N_TSV-1:0] f_flag_reg;
    logic [POP_W-1:0] fault_cnt_reg;
    logic             repair_ok_reg;
    logic             done_reg;
    logic             publish_now;
    logic             sense_bit;
    logic [POP_W-1:0] shadow_pop;
    logic             scanning;

    // Only the TSV under test matters in a phase; the rest of tsv_sense is ignored.
    assign sense_bit = scan.tsv_sense[idx_reg];
    assign scanning  = (state_reg == S_ONE) || (state_reg == S_ZERO);

    // Next-state and phase bookkeeping for the walking-one / walking-zero scan.
    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        cnt_next    = cnt_reg;
        shadow_next = shadow_reg;
        publish_now = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (scan.start) begin
                    shadow_next = '0;
                    idx_next    = '0;
                    cnt_next    = '0;
                    state_next  = S_ONE;
                end
            end
            S_ONE: begin
                if (cnt_reg == SETTLE_C) begin
                    if (sense_bit != 1'b1) begin
                        shadow_next[idx_reg] = 1'b1;
                    end
                    cnt_next   = '0;
                    state_next = S_ZERO;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_ZERO: begin
                if (cnt_reg == SETTLE_C) begin
                    if (sense_bit != 1'b0) begin
                        shadow_next[idx_reg] = 1'b1;
                    end
                    cnt_next = '0;
                    if (idx_reg == LAST_IDX) begin
                        state_next = S_PUBLISH;
                    end else begin
                        idx_next   = idx_reg + 1'b1;
                        state_next = S_ONE;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_PUBLISH: begin
                publish_now = 1'b1;
                state_next  = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Population count of the accumulated shadow flags.
    always_comb begin
        shadow_pop = '0;
        for (int i = 0; i < N_TSV; i++) begin
            shadow_pop = shadow_pop + POP_W'(shadow_reg[i]);
        end
    end

    // FSM state and scan bookkeeping registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= S_IDLE;
            idx_reg    <= '0;
            cnt_reg    <= '0;
            shadow_reg <= '0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            cnt_reg    <= cnt_next;
            shadow_reg <= shadow_next;
        end
    end

    // Published results: updated together, held until the next publish.
    always_ff @(posedge clock) begin
        if (reset) begin
            f_flag_reg    <= '0;
            fault_cnt_reg <= '0;
            repair_ok_reg <= 1'b1;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= publish_now;
            if (publish_now) begin
                f_flag_reg    <= shadow_reg;
                fault_cnt_reg <= shadow_pop;
                repair_ok_reg <= (shadow_pop <= MAX_C);
            end
        end
    end

    // Test pattern: walking one in ONE, walking zero in ZERO, all low otherwise.
    genvar gi;
    generate
        for (gi = 0; gi < N_TSV; gi++) begin : g_drive
            assign scan.tsv_drive[gi] =
                ((state_reg == S_ONE)  && (idx_reg == IDX_W'(gi))) ||
                ((state_reg == S_ZERO) && (idx_reg != IDX_W'(gi)));
        end
    endgenerate

    assign scan.tsv_test_en = scanning;
    assign scan.busy        = scanning;
    assign scan.f_flag      = f_flag_reg;
    assign scan.fault_cnt   = fault_cnt_reg;
    assign scan.repair_ok   = repair_ok_reg;
    assign scan.done        = done_reg;
endmodule
